// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding controller: EX operand mux selects and FSM states.
package hazard_pkg;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} hu_state_t;
endpackage

// File: rtl/fwd_select.sv
// One EX operand's forwarding select (EX/MEM over MEM/WB) plus its WB-to-ID read bypass.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] ex_src_i,
  input  logic [REG_ADDR_W-1:0] id_src_i,
  input  logic                  id_use_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic                  mem_regwrite_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic                  wb_regwrite_i,
  output logic [1:0]            fwd_o,
  output logic                  id_byp_o
);
  logic mem_hit, wb_hit;

  // r0 is hardwired to zero, so it never sources a forward
  assign mem_hit  = mem_regwrite_i && (mem_rd_i != '0) && (mem_rd_i == ex_src_i);
  assign wb_hit   = wb_regwrite_i  && (wb_rd_i  != '0) && (wb_rd_i  == ex_src_i);
  assign fwd_o    = mem_hit ? FWD_MEM : (wb_hit ? FWD_WB : FWD_RF);
  assign id_byp_o = wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == id_src_i) && id_use_i;
endmodule

// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes, external freeze,
// EX operand forwarding and saturating stall/flush event counters.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int LOAD_STALL_CYC = 1,
  parameter int BR_STAGE       = 3,
  parameter int CNT_W          = 16
) (
  input  logic                  clk_HU,
  input  logic                  rstn_HU,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  mem_regwrite,
  input  logic                  wb_regwrite,
  input  logic                  branch_taken,
  input  logic                  ext_stall,
  output logic                  pc_we,
  output logic                  ifid_we,
  output logic                  idex_bubble,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  id_byp_a,
  output logic                  id_byp_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);
  localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL_CYC - 1);
  localparam logic       BR_IN_MEM  = (BR_STAGE == 3);

  hu_state_t        state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             lu, pc_we_c, ifid_we_c, bubble_c, ifid_fl_c, idex_fl_c, exmem_fl_c;
  logic             stall_inc, flush_inc;
  logic [1:0]       fwd_a_c, fwd_b_c;
  logic             byp_a_c, byp_b_c;

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .ex_src_i(ex_rs), .id_src_i(id_rs), .id_use_i(id_use_rs),
    .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite),
    .wb_rd_i(wb_rd), .wb_regwrite_i(wb_regwrite),
    .fwd_o(fwd_a_c), .id_byp_o(byp_a_c)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .ex_src_i(ex_rt), .id_src_i(id_rt), .id_use_i(id_use_rt),
    .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite),
    .wb_rd_i(wb_rd), .wb_regwrite_i(wb_regwrite),
    .fwd_o(fwd_b_c), .id_byp_o(byp_b_c)
  );

  assign lu = ex_memread && (ex_rd != '0) &&
              ((id_use_rs && (ex_rd == id_rs)) || (id_use_rt && (ex_rd == id_rt)));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_we_c    = 1'b1;
    ifid_we_c  = 1'b1;
    bubble_c   = 1'b0;
    ifid_fl_c  = 1'b0;
    idex_fl_c  = 1'b0;
    exmem_fl_c = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    if (ext_stall) begin
      pc_we_c   = 1'b0;
      ifid_we_c = 1'b0;
    end else if (branch_taken) begin
      // the branch squashes whatever the pending load-use stall was protecting
      ifid_fl_c  = 1'b1;
      idex_fl_c  = 1'b1;
      exmem_fl_c = BR_IN_MEM;
      flush_inc  = 1'b1;
      state_d    = RUN;
      cnt_d      = '0;
    end else if (state_q == STALL) begin
      pc_we_c   = 1'b0;
      ifid_we_c = 1'b0;
      bubble_c  = 1'b1;
      stall_inc = 1'b1;
      cnt_d     = cnt_q - 3'd1;
      if (cnt_q == 3'd1) state_d = RUN;
    end else if (lu) begin
      pc_we_c   = 1'b0;
      ifid_we_c = 1'b0;
      bubble_c  = 1'b1;
      stall_inc = 1'b1;
      if (LOAD_STALL_CYC > 1) begin
        state_d = STALL;
        cnt_d   = STALL_INIT;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_HU or negedge rstn_HU) begin
    if (!rstn_HU) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // outputs are forced to their idle values for as long as reset is held
  assign pc_we       = rstn_HU & pc_we_c;
  assign ifid_we     = rstn_HU & ifid_we_c;
  assign idex_bubble = rstn_HU & bubble_c;
  assign ifid_flush  = rstn_HU & ifid_fl_c;
  assign idex_flush  = rstn_HU & idex_fl_c;
  assign exmem_flush = rstn_HU & exmem_fl_c;
  assign fwd_a       = rstn_HU ? fwd_a_c : FWD_RF;
  assign fwd_b       = rstn_HU ? fwd_b_c : FWD_RF;
  assign id_byp_a    = rstn_HU & byp_a_c;
  assign id_byp_b    = rstn_HU & byp_b_c;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench: three shared-stimulus instances (1-cycle stall/EX branch, 3-cycle stall/MEM branch, 2-bit counters).
module tb_hazard_fwd_unit;
  logic       clk_HU = 1'b0;
  logic       rstn_HU;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs, id_use_rt, ex_memread, mem_regwrite, wb_regwrite, branch_taken, ext_stall;

  logic [2:0] pc_we, ifid_we, idex_bubble, ifid_flush, idex_flush, exmem_flush, id_byp_a, id_byp_b;
  logic [1:0] fwd_a [3];
  logic [1:0] fwd_b [3];
  logic [15:0] stall_cnt0, flush_cnt0, stall_cnt1, flush_cnt1;
  logic [1:0]  stall_cnt2, flush_cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk_HU = ~clk_HU;

  hazard_fwd_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYC(1), .BR_STAGE(2), .CNT_W(16)) d1 (
    .clk_HU(clk_HU), .rstn_HU(rstn_HU), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite), .branch_taken(branch_taken),
    .ext_stall(ext_stall), .pc_we(pc_we[0]), .ifid_we(ifid_we[0]), .idex_bubble(idex_bubble[0]),
    .ifid_flush(ifid_flush[0]), .idex_flush(idex_flush[0]), .exmem_flush(exmem_flush[0]),
    .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]), .id_byp_a(id_byp_a[0]), .id_byp_b(id_byp_b[0]),
    .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
  );

  hazard_fwd_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYC(3), .BR_STAGE(3), .CNT_W(16)) d3 (
    .clk_HU(clk_HU), .rstn_HU(rstn_HU), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite), .branch_taken(branch_taken),
    .ext_stall(ext_stall), .pc_we(pc_we[1]), .ifid_we(ifid_we[1]), .idex_bubble(idex_bubble[1]),
    .ifid_flush(ifid_flush[1]), .idex_flush(idex_flush[1]), .exmem_flush(exmem_flush[1]),
    .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]), .id_byp_a(id_byp_a[1]), .id_byp_b(id_byp_b[1]),
    .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
  );

  hazard_fwd_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYC(1), .BR_STAGE(3), .CNT_W(2)) ds (
    .clk_HU(clk_HU), .rstn_HU(rstn_HU), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite), .branch_taken(branch_taken),
    .ext_stall(ext_stall), .pc_we(pc_we[2]), .ifid_we(ifid_we[2]), .idex_bubble(idex_bubble[2]),
    .ifid_flush(ifid_flush[2]), .idex_flush(idex_flush[2]), .exmem_flush(exmem_flush[2]),
    .fwd_a(fwd_a[2]), .fwd_b(fwd_b[2]), .id_byp_a(id_byp_a[2]), .id_byp_b(id_byp_b[2]),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_memread = 0;
    mem_rd = 0; wb_rd = 0; mem_regwrite = 0; wb_regwrite = 0;
    branch_taken = 0; ext_stall = 0;
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk_HU);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rstn_HU = 1'b0;
    #3;
    rstn_HU = 1'b1;
    tick();
  endtask

  task automatic load_use();
    ex_memread = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1;
  endtask

  initial begin
    idle();
    rstn_HU = 1'b0;
    // outputs held idle under reset even when forwarding inputs would fire
    mem_regwrite = 1; mem_rd = 5; ex_rs = 5; wb_regwrite = 1; wb_rd = 5; id_rs = 5; id_use_rs = 1;
    #2;
    chk("rst_pc_we", pc_we[0], 0);
    chk("rst_ifid_we", ifid_we[1], 0);
    chk("rst_fwd_a", fwd_a[0], 0);
    chk("rst_byp_a", id_byp_a[0], 0);
    chk("rst_stall_cnt", stall_cnt1, 0);
    chk("rst_flush_cnt", flush_cnt0, 0);
    #1;
    rstn_HU = 1'b1;
    idle();
    tick();
    chk("post_rst_pc_we", pc_we[0], 1);

    // forwarding priority and r0 exclusion
    mem_rd = 5; wb_rd = 5; ex_rs = 5; ex_rt = 5; mem_regwrite = 1; wb_regwrite = 1;
    #1;
    chk("fwd_a_mem", fwd_a[0], 2'b10);
    chk("fwd_b_mem", fwd_b[1], 2'b10);
    mem_regwrite = 0;
    #1;
    chk("fwd_a_wb", fwd_a[0], 2'b01);
    chk("fwd_b_wb", fwd_b[0], 2'b01);
    ex_rs = 0; mem_rd = 0; wb_rd = 0; mem_regwrite = 1;
    #1;
    chk("fwd_a_r0", fwd_a[0], 2'b00);
    wb_rd = 7; id_rs = 7; id_use_rs = 1; id_rt = 7; id_use_rt = 0;
    #1;
    chk("byp_a_hit", id_byp_a[0], 1);
    chk("byp_b_unused", id_byp_b[0], 0);

    // load-use: 1-cycle (d1) and 3-cycle (d3) stalls side by side
    do_reset();
    load_use();
    #1;
    chk("lu1_pc_we", pc_we[0], 0);
    chk("lu1_bubble", idex_bubble[0], 1);
    chk("lu3_bubble_c1", idex_bubble[1], 1);
    tick();
    idle();
    #1;
    chk("lu1_resume_pc_we", pc_we[0], 1);
    chk("lu1_resume_bubble", idex_bubble[0], 0);
    chk("lu1_stall_cnt", stall_cnt0, 1);
    chk("lu3_bubble_c2", idex_bubble[1], 1);
    chk("lu3_pc_we_c2", pc_we[1], 0);
    tick();
    chk("lu3_bubble_c3", idex_bubble[1], 1);
    tick();
    chk("lu3_done_bubble", idex_bubble[1], 0);
    chk("lu3_done_pc_we", pc_we[1], 1);
    chk("lu3_stall_cnt", stall_cnt1, 3);

    // taken branch on the second stall cycle abandons the stall
    do_reset();
    load_use();
    tick();
    idle();
    branch_taken = 1;
    #1;
    chk("br_ifid_flush", ifid_flush[1], 1);
    chk("br_idex_flush", idex_flush[1], 1);
    chk("br_exmem_flush_mem", exmem_flush[1], 1);
    chk("br_exmem_flush_ex", exmem_flush[0], 0);
    chk("br_pc_we", pc_we[1], 1);
    chk("br_bubble", idex_bubble[1], 0);
    tick();
    branch_taken = 0;
    #1;
    chk("br_after_pc_we", pc_we[1], 1);
    chk("br_after_bubble", idex_bubble[1], 0);
    chk("br_flush_cnt", flush_cnt1, 1);
    chk("br_flush_cnt_d1", flush_cnt0, 1);

    // external freeze during STALL with two stall cycles left
    do_reset();
    load_use();
    tick();
    idle();
    ext_stall = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ext_pc_we", pc_we[1], 0);
      chk("ext_bubble", idex_bubble[1], 0);
      chk("ext_stall_cnt_held", stall_cnt1, 1);
      tick();
    end
    ext_stall = 0;
    #1;
    chk("ext_resume_bubble1", idex_bubble[1], 1);
    tick();
    chk("ext_resume_bubble2", idex_bubble[1], 1);
    tick();
    chk("ext_done_pc_we", pc_we[1], 1);
    chk("ext_done_stall_cnt", stall_cnt1, 3);

    // asynchronous reset in the middle of a stall
    do_reset();
    load_use();
    tick();
    idle();
    #1;
    chk("pre_rst_bubble", idex_bubble[1], 1);
    rstn_HU = 1'b0;
    #1;
    chk("midrst_bubble", idex_bubble[1], 0);
    chk("midrst_pc_we", pc_we[1], 0);
    chk("midrst_stall_cnt", stall_cnt1, 0);
    #1;
    rstn_HU = 1'b1;
    tick();
    chk("midrst_after_pc_we", pc_we[1], 1);
    chk("midrst_after_bubble", idex_bubble[1], 0);

    // 2-bit stall counter saturates at 3
    do_reset();
    load_use();
    tick();
    chk("sat_cnt_1", stall_cnt2, 1);
    tick();
    chk("sat_cnt_2", stall_cnt2, 2);
    tick();
    chk("sat_cnt_3", stall_cnt2, 3);
    tick();
    chk("sat_cnt_4", stall_cnt2, 3);
    tick();
    chk("sat_cnt_5", stall_cnt2, 3);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
